// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory arbiter slice.
package dmem_pkg;

    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 8;

    localparam logic [NUM_LANES-1:0] BE_FULL = 4'b1111;
    localparam logic [NUM_LANES-1:0] BE_NONE = 4'b0000;

    typedef enum logic {
        PORT_CORE = 1'b0,
        PORT_DMA  = 1'b1
    } port_e;

    // Saturating burst counter step.
    function automatic logic [3:0] burst_inc(input logic [3:0] cnt, input logic [3:0] max_cnt);
        logic [3:0] nxt;
        if (cnt < max_cnt) begin
            nxt = cnt + 4'd1;
        end else begin
            nxt = cnt;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester's connection to the data-memory arbiter.
interface dmem_arbiter_if
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();

    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [NUM_LANES-1:0]  be;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  gnt;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/dmem_be_merge.sv
// Builds the word written back on a partial store from new and current lanes.
module dmem_be_merge
    import dmem_pkg::*;
(
    input  logic [NUM_LANES-1:0]        be,
    input  logic [NUM_LANES*LANE_W-1:0] wdata,
    input  logic [NUM_LANES*LANE_W-1:0] rdata,
    output logic [NUM_LANES*LANE_W-1:0] merged
);

    // Per-lane select between store data and the memory's current contents
    always_comb begin
        merged = {(NUM_LANES*LANE_W){1'b0}};
        for (int i = 0; i < NUM_LANES; i++) begin
            if (be[i]) begin
                merged[i*LANE_W +: LANE_W] = wdata[i*LANE_W +: LANE_W];
            end else begin
                merged[i*LANE_W +: LANE_W] = rdata[i*LANE_W +: LANE_W];
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin, burst-limited sharing of one data-memory port between the core
// and the debug/DMA loader, with read-merge-write partial stores.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    dmem_arbiter_if.slave         m0,
    dmem_arbiter_if.slave         m1,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [3:0] MAX_BURST_C = 4'(MAX_BURST);

    port_e                 last_grant_r;
    logic [3:0]            burst_cnt_r;
    port_e                 sel_s;
    logic                  gnt_s;
    logic                  rd_gnt_s;
    logic                  sel_we_s;
    logic [ADDR_WIDTH-1:0] sel_addr_s;
    logic [NUM_LANES-1:0]  sel_be_s;
    logic [DATA_WIDTH-1:0] sel_wdata_s;
    logic [DATA_WIDTH-1:0] merged_s;

    // Choose the winner; a zero burst count means no burst is running yet
    always_comb begin
        sel_s = PORT_CORE;
        gnt_s = 1'b0;
        if (rst) begin
            gnt_s = 1'b0;
        end else if (m0.req && m1.req) begin
            gnt_s = 1'b1;
            if ((burst_cnt_r != 4'd0) && (burst_cnt_r < MAX_BURST_C)) begin
                sel_s = last_grant_r;
            end else if (last_grant_r == PORT_CORE) begin
                sel_s = PORT_DMA;
            end else begin
                sel_s = PORT_CORE;
            end
        end else if (m0.req) begin
            gnt_s = 1'b1;
            sel_s = PORT_CORE;
        end else if (m1.req) begin
            gnt_s = 1'b1;
            sel_s = PORT_DMA;
        end else begin
            gnt_s = 1'b0;
        end
    end

    assign m0.gnt   = gnt_s && (sel_s == PORT_CORE);
    assign m1.gnt   = gnt_s && (sel_s == PORT_DMA);
    assign rd_gnt_s = gnt_s && !sel_we_s;

    // Route the winning port's request fields
    always_comb begin
        case (sel_s)
            PORT_CORE: begin
                sel_we_s    = m0.we;
                sel_addr_s  = m0.addr;
                sel_be_s    = m0.be;
                sel_wdata_s = m0.wdata;
            end
            PORT_DMA: begin
                sel_we_s    = m1.we;
                sel_addr_s  = m1.addr;
                sel_be_s    = m1.be;
                sel_wdata_s = m1.wdata;
            end
            default: begin
                sel_we_s    = 1'b0;
                sel_addr_s  = {ADDR_WIDTH{1'b0}};
                sel_be_s    = BE_NONE;
                sel_wdata_s = {DATA_WIDTH{1'b0}};
            end
        endcase
    end

    dmem_be_merge u_be_merge (
        .be     (sel_be_s),
        .wdata  (sel_wdata_s),
        .rdata  (mem_rdata),
        .merged (merged_s)
    );

    // Drive the memory; a partial store reads and writes in the same cycle
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = {ADDR_WIDTH{1'b0}};
        mem_wdata = {DATA_WIDTH{1'b0}};
        if (rd_gnt_s) begin
            mem_read = 1'b1;
            mem_addr = sel_addr_s;
        end else if (gnt_s && (sel_be_s == BE_FULL)) begin
            mem_write = 1'b1;
            mem_addr  = sel_addr_s;
            mem_wdata = sel_wdata_s;
        end else if (gnt_s && (sel_be_s != BE_NONE)) begin
            mem_read  = 1'b1;
            mem_write = 1'b1;
            mem_addr  = sel_addr_s;
            mem_wdata = merged_s;
        end else begin
            // Idle, or an empty-lane store that only consumes the slot.
            mem_write = 1'b0;
        end
    end

    // Owner and burst length bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_r <= PORT_DMA;
            burst_cnt_r  <= 4'd0;
        end else if (gnt_s) begin
            if (sel_s == last_grant_r) begin
                burst_cnt_r <= burst_inc(burst_cnt_r, MAX_BURST_C);
            end else begin
                last_grant_r <= sel_s;
                burst_cnt_r  <= 4'd1;
            end
        end
    end

    // Registered load return to the requesting port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m0.rvalid <= 1'b0;
            m1.rvalid <= 1'b0;
            m0.rdata  <= {DATA_WIDTH{1'b0}};
            m1.rdata  <= {DATA_WIDTH{1'b0}};
        end else begin
            m0.rvalid <= rd_gnt_s && (sel_s == PORT_CORE);
            m1.rvalid <= rd_gnt_s && (sel_s == PORT_DMA);
            if (rd_gnt_s && (sel_s == PORT_CORE)) begin
                m0.rdata <= mem_rdata;
            end
            if (rd_gnt_s && (sel_s == PORT_DMA)) begin
                m1.rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed bench for dmem_arbiter against a transaction-level
// model of grants, memory contents and load returns.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    localparam int AW        = 32;
    localparam int DW        = 32;
    localparam int MB        = 4;
    localparam int MEM_WORDS = 64;

    typedef struct packed {
        logic          req;
        logic          we;
        logic [AW-1:0] addr;
        logic [3:0]    be;
        logic [DW-1:0] wdata;
    } txn_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mem_clear = 1'b1;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] mem_array [MEM_WORDS];

    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m0_if ();
    dmem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m1_if ();

    dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk       (clk),
        .rst       (rst),
        .m0        (m0_if),
        .m1        (m1_if),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Memory behind the arbiter: combinational read, write at the edge
    assign mem_rdata = mem_array[mem_addr[7:2]];
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < MEM_WORDS; i++) mem_array[i] <= 32'h0;
        end else if (mem_write) begin
            mem_array[mem_addr[7:2]] <= mem_wdata;
        end
    end

    logic [DW-1:0] ref_mem [MEM_WORDS];
    logic [DW-1:0] exp_rdata [2];
    logic          exp_rvalid [2];
    int            ref_owner;
    int            ref_run;
    txn_t          cur [2];
    int            n_checks;
    int            n_fails;
    int            exp_seq [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic txn_t make_txn(input logic req, input logic we, input logic [31:0] addr,
                                      input logic [3:0] be, input logic [31:0] wdata);
        txn_t t;
        t.req = req; t.we = we; t.addr = addr; t.be = be; t.wdata = wdata;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        t.req   = ($urandom_range(0, 9) < 7);
        t.we    = 1'($urandom_range(0, 1));
        t.addr  = {24'h0, 8'($urandom)};
        case ($urandom_range(0, 3))
            0:       t.be = BE_FULL;
            1:       t.be = 4'b0000;
            default: t.be = 4'($urandom);
        endcase
        t.wdata = $urandom;
        return t;
    endfunction

    // Round-robin with burst limit, expressed as owner + run length.
    function automatic int predict_grant();
        if (cur[0].req && !cur[1].req) return 0;
        if (!cur[0].req && cur[1].req) return 1;
        if (!cur[0].req && !cur[1].req) return -1;
        if (ref_run > 0 && ref_run < MB) return ref_owner;
        return 1 - ref_owner;
    endfunction

    task automatic model_reset();
        ref_owner     = 1;
        ref_run       = 0;
        exp_rvalid[0] = 1'b0;
        exp_rvalid[1] = 1'b0;
        exp_rdata[0]  = 32'h0;
        exp_rdata[1]  = 32'h0;
    endtask

    task automatic drive_ports();
        m0_if.req = cur[0].req; m0_if.we = cur[0].we; m0_if.addr = cur[0].addr;
        m0_if.be = cur[0].be; m0_if.wdata = cur[0].wdata;
        m1_if.req = cur[1].req; m1_if.we = cur[1].we; m1_if.addr = cur[1].addr;
        m1_if.be = cur[1].be; m1_if.wdata = cur[1].wdata;
    endtask

    // One clock cycle: drive, check grant/memory controls, then check returns.
    task automatic step(output int g);
        txn_t t;
        int   w;
        @(negedge clk);
        drive_ports();
        #1;
        g = predict_grant();
        check_val("gnt0", 32'(m0_if.gnt), 32'(g == 0));
        check_val("gnt1", 32'(m1_if.gnt), 32'(g == 1));
        exp_rvalid[0] = 1'b0;
        exp_rvalid[1] = 1'b0;
        if (g >= 0) begin
            t = cur[g];
            w = int'(t.addr[7:2]);
            if (!t.we) begin
                exp_rvalid[g] = 1'b1;
                exp_rdata[g]  = ref_mem[w];
                check_val("rd_ctrl", {30'h0, mem_read, mem_write}, 32'h2);
                check_val("rd_addr", mem_addr, t.addr);
            end else begin
                check_val("wr_en", 32'(mem_write), 32'(t.be != 4'b0000));
                if (t.be == 4'b0000) check_val("noop_rd", 32'(mem_read), 32'h0);
                for (int l = 0; l < 4; l++) begin
                    if (t.be[l]) ref_mem[w][8*l +: 8] = t.wdata[8*l +: 8];
                end
            end
            if (g == ref_owner) begin
                if (ref_run < MB) ref_run++;
            end else begin
                ref_owner = g;
                ref_run   = 1;
            end
        end else begin
            check_val("idle_ctrl", {30'h0, mem_read, mem_write}, 32'h0);
        end
        @(posedge clk);
        #1;
        check_val("rvalid0", 32'(m0_if.rvalid), 32'(exp_rvalid[0]));
        check_val("rvalid1", 32'(m1_if.rvalid), 32'(exp_rvalid[1]));
        check_val("rdata0", m0_if.rdata, exp_rdata[0]);
        check_val("rdata1", m1_if.rdata, exp_rdata[1]);
    endtask

    initial begin
        int   g;
        txn_t idle;
        n_checks = 0;
        n_fails  = 0;
        idle     = make_txn(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        cur[0]   = idle;
        cur[1]   = idle;
        drive_ports();
        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_rvalid", {30'h0, m0_if.rvalid, m1_if.rvalid}, 32'h0);
        check_val("rst_rdata0", m0_if.rdata, 32'h0);
        check_val("rst_rdata1", m1_if.rdata, 32'h0);
        @(negedge clk);
        rst       = 1'b0;
        mem_clear = 1'b0;

        // Continuous contention from reset
        cur[0] = make_txn(1'b1, 1'b0, 32'h40, 4'hF, 32'h0);
        cur[1] = make_txn(1'b1, 1'b0, 32'h44, 4'hF, 32'h0);
        for (int i = 0; i < 12; i++) begin
            step(g);
            check_val("contend_seq", 32'(g), 32'(exp_seq[i]));
        end
        cur[0] = idle; cur[1] = idle;
        step(g);

        // Single-port full store then load
        cur[0] = make_txn(1'b1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
        step(g);
        cur[0] = make_txn(1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
        step(g);
        check_val("single_rd", m0_if.rdata, 32'hDEADBEEF);

        // Partial store merges with existing word
        cur[0] = make_txn(1'b1, 1'b1, 32'h20, 4'hF, 32'h11223344);
        step(g);
        cur[0] = idle;
        cur[1] = make_txn(1'b1, 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD);
        step(g);
        cur[1] = make_txn(1'b1, 1'b0, 32'h22, 4'h0, 32'h0);
        step(g);
        check_val("partial_rd", m1_if.rdata, 32'h11BB33DD);
        cur[1] = idle;

        // Alternating single requesters
        for (int i = 0; i < 8; i++) begin
            cur[i % 2]       = make_txn(1'b1, 1'b0, 32'(4 * i), 4'h0, 32'h0);
            cur[1 - (i % 2)] = idle;
            step(g);
            check_val("alt_gnt", 32'(g), 32'(i % 2));
        end
        cur[0] = idle; cur[1] = idle;

        // Read then write same word, then write then read
        cur[0] = make_txn(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
        step(g);
        cur[0] = make_txn(1'b1, 1'b1, 32'h10, 4'hF, 32'h12345678);
        step(g);
        check_val("rd_before_wr", m0_if.rdata, 32'hDEADBEEF);
        cur[0] = make_txn(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
        step(g);
        check_val("wr_then_rd", m0_if.rdata, 32'h12345678);
        cur[0] = idle;

        // Empty-lane store is granted but leaves memory alone
        cur[1] = make_txn(1'b1, 1'b1, 32'h10, 4'h0, 32'hFFFFFFFF);
        step(g);
        check_val("noop_gnt", 32'(g), 32'h1);
        cur[1] = make_txn(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
        step(g);
        check_val("noop_keep", m1_if.rdata, 32'h12345678);
        cur[1] = idle;

        // Reset while a load return is showing
        cur[0] = make_txn(1'b1, 1'b0, 32'h20, 4'h0, 32'h0);
        step(g);
        rst = 1'b1;
        #1;
        check_val("midrst_rvalid0", 32'(m0_if.rvalid), 32'h0);
        check_val("midrst_rdata0", m0_if.rdata, 32'h0);
        check_val("midrst_gnt0", 32'(m0_if.gnt), 32'h0);
        check_val("midrst_ctrl", {30'h0, mem_read, mem_write}, 32'h0);
        check_val("midrst_addr", mem_addr, 32'h0);
        model_reset();
        @(negedge clk);
        rst    = 1'b0;
        cur[0] = make_txn(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
        cur[1] = make_txn(1'b1, 1'b0, 32'h20, 4'h0, 32'h0);
        step(g);
        check_val("post_rst_first", 32'(g), 32'h0);

        // Random traffic; a request is held until its grant
        for (int i = 0; i < 600; i++) begin
            step(g);
            for (int p = 0; p < 2; p++) begin
                if (g == p || !cur[p].req) cur[p] = rand_txn();
            end
        end
        cur[0] = idle; cur[1] = idle;
        step(g);

        for (int w = 0; w < MEM_WORDS; w++) begin
            check_val("mem_final", mem_array[w], ref_mem[w]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port, word-addressed data memory between two requesters: port 0 (core load/store unit) and port 1 (debug/DMA loader).
- Arbitration is round-robin with a bounded burst count.
- Partial-word stores are handled by a same-cycle read-merge-write, driven through the memory's combinational read.
- Load data is registered and returned one cycle after grant with a valid pulse.

Parameters:
- ADDR_WIDTH, 32, byte-address width of requester and memory ports.
- DATA_WIDTH, 32, word width; must be 32 (4 byte lanes).
- MAX_BURST, 4, maximum consecutive grants to one port while the other is requesting; range 1..15.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- m0_req  in  1  port 0 request, held until granted.
- m0_we  in  1  port 0 write (1) / read (0).
- m0_addr  in  ADDR_WIDTH  port 0 byte address; bits [1:0] ignored.
- m0_be  in  4  port 0 byte enables for writes; ignored on reads.
- m0_wdata  in  DATA_WIDTH  port 0 write data, lane-aligned.
- m0_gnt  out  1  port 0 grant, combinational, same cycle as access.
- m0_rvalid  out  1  port 0 read data valid, one cycle after a read grant.
- m0_rdata  out  DATA_WIDTH  port 0 read data (registered).
- m1_req, m1_we, m1_addr, m1_be, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: identical set for port 1.
- mem_read  out  1  to memory read_mem.
- mem_write  out  1  to memory write_mem.
- mem_addr  out  ADDR_WIDTH  to memory addr (byte address, passed unchanged).
- mem_wdata  out  DATA_WIDTH  to memory in_data.
- mem_rdata  in  DATA_WIDTH  from memory out_data (combinational).

Behaviour:
- Reset (async, rst=1):
  - last_grant=1, so port 0 wins the first contention.
  - burst_cnt=0.
  - m0_rvalid=m1_rvalid=0; m0_rdata=m1_rdata=0.
  - While rst is high: gnt outputs 0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
- Arbitration (combinational, every cycle):
  - Only one port requesting -> that port is granted.
  - Both requesting -> the port not equal to last_grant is granted.
  - Exception: if burst_cnt < MAX_BURST and last_grant still requesting, grant last_grant (continue burst).
  - At most one gnt high per cycle; no grant when neither requests.
- Burst counter:
  - On each grant to the same port as last_grant, burst_cnt increments, saturating at MAX_BURST.
  - On a grant to the other port, burst_cnt=1 and last_grant flips.
  - No grant that cycle -> burst_cnt holds.
- Granted read:
  - mem_read=1, mem_write=0, mem_addr=granted addr.
  - mem_rdata is captured into that port's rdata at the next edge; that port's rvalid=1 for exactly one cycle.
  - rdata holds until the next read to the same port.
- Granted write, be=4'b1111: mem_write=1, mem_read=0, mem_wdata=wdata.
- Granted write, partial be (any other nonzero value):
  - mem_read=1 and mem_write=1 in the same cycle.
  - mem_wdata = per-lane mux: be[i] ? wdata lane i : mem_rdata lane i.
  - Memory commits at the edge; no rvalid.
- Write with be=4'b0000: granted, with mem_write=0 and mem_read=0; a no-op that still consumes the slot.
- Writes never produce rvalid.
- Back-to-back:
  - A port may be granted every cycle.
  - A read followed by a write to the same word returns pre-write data.
  - A write followed by a read returns the written data.
- No idle cycle is inserted between owners.
- Reset mid-operation: rvalid pending at the edge is cleared; any in-flight write in the reset cycle is not issued, since mem_write is forced 0.

Decomposition:
- Package dmem_pkg holds:
  - lane constants: NUM_LANES=4, LANE_W=8, BE_FULL=4'b1111;
  - a port-index encoding: PORT_CORE=0, PORT_DMA=1.
- One natural sub-module, dmem_be_merge: combinational, inputs be, wdata, rdata; output merged word.
- Arbiter state (last_grant, burst_cnt) and response registers stay in dmem_arbiter.

Test Plan:
- Reset behaviour: rst pulse mid-simulation with m0 read in flight -> m0_rvalid drops immediately; after release, first contention grants port 0.
- Single-port traffic: m0 writes 0xDEADBEEF to 0x10 (be=F), then reads 0x10 -> m0_rvalid one cycle after gnt, m0_rdata=0xDEADBEEF; m1_gnt stays 0.
- Partial store: word 0x20 holds 0x11223344; m1 writes wdata=0xAABBCCDD be=0101 -> subsequent read returns 0x11BB33DD.
- Contention with MAX_BURST=4: both request continuously for 12 cycles -> grant sequence 0,0,0,0,1,1,1,1,0,0,0,0.
- Alternating single requests: m0 and m1 each request on alternate cycles -> each granted immediately and rvalid routed only to the originating port.
- Ordering and no-op write: read then write to the same word in consecutive cycles -> read returns old value; write with be=0 -> memory unchanged, gnt asserted, no rvalid.
